// File: rtl/float_div_arbiter.sv
// float_div_arbiter: round-robin issue of operand pairs to one shared divider
// with in-order result routing by tag FIFO. Optional stats: FDIV_ARB_STATS_EN.
module float_div_arbiter #(
  parameter int SIZE      = 64,
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ*SIZE-1:0]   req_a_tdata,
  input  logic [NUM_REQ*SIZE-1:0]   req_b_tdata,
  input  logic [NUM_REQ-1:0]        req_tvalid,
  output logic [NUM_REQ-1:0]        req_tready,
  output logic [SIZE-1:0]           rsp_tdata,
  output logic [NUM_REQ-1:0]        rsp_tvalid,
  input  logic [NUM_REQ-1:0]        rsp_tready,
  output logic [SIZE-1:0]           div_a_tdata,
  output logic                      div_a_tvalid,
  input  logic                      div_a_tready,
  output logic [SIZE-1:0]           div_b_tdata,
  output logic                      div_b_tvalid,
  input  logic                      div_b_tready,
  input  logic [SIZE-1:0]           div_result_tdata,
  input  logic                      div_result_tvalid,
  output logic                      div_result_tready,
`ifdef FDIV_ARB_STATS_EN
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic [31:0]                    stall_cycles
`else
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH+1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t r_state, w_state_nx;

  logic [IW-1:0]      r_grant, w_grant_nx;
  logic [IW-1:0]      r_rr, w_rr_nx;
  logic [IW-1:0]      r_tags [TAG_DEPTH];
  logic [AW-1:0]      r_wr, r_rd;
  logic [CW-1:0]      r_count;

  logic               w_issue, w_pop, w_nempty;
  logic               w_room, w_go;
  logic [IW-1:0]      w_head, w_base;
  logic [NUM_REQ-1:0] w_cand;
  logic [IW:0]        w_pick;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] g);
    return (int'(g) == NUM_REQ-1) ? '0 : g + 1'b1;
  endfunction

  // first valid requester at or after base, wrapping; MSB flags a hit
  function automatic logic [IW:0] f_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      base
  );
    logic [IW:0]   r;
    logic [IW-1:0] idx;
    r = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = IW'((int'(base) + k) % NUM_REQ);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // handshake qualifiers and FIFO head
  always_comb begin
    w_nempty = (r_count != '0);
    w_head   = r_tags[r_rd];
    w_issue  = (r_state == OFFER) && div_a_tready && div_b_tready;
    w_pop    = w_nempty && div_result_tvalid && rsp_tready[w_head];
  end

  // grant selection; an accepted pair is masked from the same-cycle re-pick
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_rr_nx    = r_rr;
    w_base     = r_rr;
    w_cand     = req_tvalid;
    w_room     = (r_count < CW'(TAG_DEPTH));
    if (w_issue) begin
      w_rr_nx = f_inc(r_grant);
      w_base  = f_inc(r_grant);
      w_cand  = req_tvalid & ~(NUM_REQ'(1) << r_grant);
      w_room  = (r_count < CW'(TAG_DEPTH-1));
    end
    w_pick = f_pick(w_cand, w_base);
    w_go   = w_pick[IW] && w_room;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nx = OFFER;
          w_grant_nx = w_pick[IW-1:0];
        end
      end
      OFFER: begin
        if (w_issue) begin
          w_state_nx = w_go ? OFFER : IDLE;
          if (w_go) w_grant_nx = w_pick[IW-1:0];
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // operand offer, acceptance and return-path routing
  always_comb begin
    div_a_tvalid = (r_state == OFFER);
    div_b_tvalid = (r_state == OFFER);
    div_a_tdata  = req_a_tdata[int'(r_grant)*SIZE +: SIZE];
    div_b_tdata  = req_b_tdata[int'(r_grant)*SIZE +: SIZE];
    req_tready   = '0;
    if (w_issue) req_tready[r_grant] = 1'b1;
    rsp_tdata    = div_result_tdata;
    rsp_tvalid   = '0;
    if (w_nempty) rsp_tvalid[w_head] = div_result_tvalid;
    div_result_tready = w_nempty ? rsp_tready[w_head] : 1'b0;
    outstanding  = r_count;
  end

  // FSM state, locked grant and round-robin pointer
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_rr    <= w_rr_nx;
    end
  end

  // tag FIFO pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_issue) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      unique case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // tag storage: owner id of each issued divide
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TAG_DEPTH; i++) r_tags[i] <= '0;
    end else if (w_issue) begin
      r_tags[r_wr] <= r_grant;
    end
  end

`ifdef FDIV_ARB_STATS_EN
  logic [31:0] r_stall;

  // cycles spent offering without acceptance, saturating
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stall <= '0;
    end else if ((r_state == OFFER) && !w_issue && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
